// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared types and constants for the SPI command master.
//   state_e      controller states
//   FRAME_BITS   bits per frame (R/W, 7-bit address, 8-bit data, MSB first)
//   *_BIT/_MSB   field positions inside the frame
//   build_frame  assembles the outgoing frame from the request fields
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP,
        DONE
    } state_e;

    localparam int FRAME_BITS   = 16;
    localparam int HALF_PERIODS = 2 * FRAME_BITS;

    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    // Reads shift out zeros in the data field: wdata is meaningless there.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       rw,
        input logic [6:0] addr,
        input logic [7:0] wdata
    );
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[RW_BIT]            = rw;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:0]        = rw ? wdata : 8'h00;
        return f;
    endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// spi_cmd_master_if: request/response handshake plus SPI pins.
//   start/rw/addr/wdata  frame request (user -> master)
//   busy/done/rdata      status and read result (master -> user)
//   sclk/ncs/copi        SPI outputs, cipo SPI input
// master modport: the controller's view; slave modport: the user/peripheral view.
interface spi_cmd_master_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       sclk;
    logic       ncs;
    logic       copi;
    logic       cipo;

    modport master (
        input  start, rw, addr, wdata, cipo,
        output busy, done, rdata, sclk, ncs, copi
    );

    modport slave (
        output start, rw, addr, wdata, cipo,
        input  busy, done, rdata, sclk, ncs, copi
    );
endinterface

// File: rtl/spi_half_tick.sv
// spi_half_tick: divides clk by CLK_DIV and emits a one-cycle tick at the
// last cycle of every SCLK half-period.
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        count enable; counter is held at zero while low
//   tick_o      high on the final cycle of each half-period
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == LAST);
        // Clearing while disabled makes every frame start on a fresh half-period.
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: SPI mode-0 initiator for 16-bit register write/read frames.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         spi_cmd_master_if.master (request, status, SPI pins)
// Every output is a register fed from the current state, so outputs lag the
// state by one clock and there is no combinational input-to-output path.
module spi_cmd_master
    import spi_cmd_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spi_cmd_master_if.master         bus
);

    localparam logic [4:0] HP_LAST      = 5'(HALF_PERIODS - 1);
    localparam logic [4:0] HP_LAST_FALL = 5'(HALF_PERIODS - 2);

    state_e                state_q, state_d;
    logic [4:0]            hp_q, hp_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [7:0]            rx_q, rx_d;
    logic                  rw_q, rw_d;

    logic       ncs_q, ncs_d;
    logic       sclk_q, sclk_d;
    logic       copi_q, copi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;

    logic tick;

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   ((state_q != IDLE) && (state_q != DONE)),
        .tick_o (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)                  state_d = SETUP;
            SETUP:   if (tick)                       state_d = SHIFT;
            SHIFT:   if (tick && (hp_q == HP_LAST))  state_d = HOLD;
            HOLD:    if (tick)                       state_d = GAP;
            GAP:     if (tick)                       state_d = DONE;
            DONE:                                    state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered pins/status
    always_comb begin
        ncs_d   = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
        sclk_d  = (state_q == SHIFT) && !hp_q[0];
        copi_d  = ncs_d ? 1'b0 : tx_q[FRAME_BITS-1];
        busy_d  = (state_q != IDLE);
        done_d  = (state_q == DONE);
        rdata_d = ((state_q == DONE) && !rw_q) ? rx_q : rdata_q;
    end

    // Datapath: frame latch, half-period counter, shift registers
    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        rw_d = rw_q;
        hp_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_d = build_frame(bus.rw, bus.addr, bus.wdata);
                    rw_d = bus.rw;
                    rx_d = '0;
                end
            end
            SHIFT: begin
                hp_d = tick ? hp_q + 5'd1 : hp_q;
                // Sample on the edge where the SCLK register goes high.
                if (sclk_d && !sclk_q) begin
                    rx_d = {rx_q[6:0], bus.cipo};
                end
                // End of a high half-period is a falling edge; the last one
                // keeps COPI on bit 0 through HOLD.
                if (tick && !hp_q[0] && (hp_q != HP_LAST_FALL)) begin
                    tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rw_q    <= 1'b0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            hp_q    <= hp_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ncs   = ncs_q;
    assign bus.sclk  = sclk_q;
    assign bus.copi  = copi_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- SPI mode-0 controller: the initiating end of the 16-bit register-write/read protocol that the chip's SPI peripheral decodes.
- Used on the FPGA/bench side, and as an on-chip test initiator, to drive nCS/SCLK/COPI into the peripheral's register file and capture CIPO.
- Frame, MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range >= 1.
- FRAME_BITS, 16, bits per frame; fixed, not overridable by users.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a frame; sampled only in IDLE.
- rw  input  1  1 = write, 0 = read; latched on accepted start.
- addr  input  7  register address; latched on accepted start.
- wdata  input  8  write data, ignored on reads; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done, inclusive.
- done  output  1  one-cycle pulse at frame end.
- rdata  output  8  last 8 CIPO bits sampled; updated only on a read frame, held otherwise.
- sclk  output  1  SPI clock, idles low.
- ncs  output  1  chip select, active-low, idles high.
- copi  output  1  serial data out.
- cipo  input  1  serial data in.

Behaviour:
- Clocking: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: ncs=1, sclk=0, copi=0, busy=0, done=0, rdata=8'h00; state=IDLE; shift register and counters cleared.
- All SPI outputs are registered; no combinational path from any input to any output.
- IDLE:
  - ncs=1, sclk=0, copi=0.
  - start=1 latches frame={rw,addr,wdata} and moves to SETUP.
- SETUP, CLK_DIV cycles:
  - ncs=0, sclk=0, copi=frame[15], busy=1.
- SHIFT, 32 half-periods of CLK_DIV cycles each, first half-period sclk=1:
  - rising sclk: sample cipo into the receive shift register.
  - falling sclk: present the next frame bit on copi.
  - After the 16th falling edge: sclk=0 and copi holds the last bit.
- HOLD, CLK_DIV cycles:
  - ncs=0, sclk=0.
- GAP, CLK_DIV cycles:
  - ncs=1, copi=0.
- DONE, 1 cycle:
  - done=1, busy=1.
  - If rw was 0, rdata gets receive bits 7:0, i.e. the samples from the 9th–16th rising edges.
  - Next state is IDLE.
- Latency:
  - The edge that samples start is edge 0.
  - ncs falls at edge 1.
  - done is high during the cycle following edge 35*CLK_DIV+1 (CLK_DIV=4 gives 141).
  - SCLK period is 2*CLK_DIV; ncs low time is 34*CLK_DIV cycles.
- start while busy is ignored and not queued.
- start high during the DONE cycle is not accepted.
- start held high continuously: the next frame is accepted in the first IDLE cycle, so the inter-frame nCS-high time is CLK_DIV + 2 cycles.
- Latched fields are immune to changes on rw/addr/wdata mid-frame.
- Reset mid-frame: outputs return to reset values immediately (asynchronous), no done pulse, rdata=0.
- Division counter: width $clog2(CLK_DIV+1), wraps at CLK_DIV-1. Bit counter: 5 bits, counts half-periods 0..31.

Decomposition:
- Package spi_cmd_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, HOLD, GAP, DONE};
  - FRAME_BITS=16;
  - field positions RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7.
- One natural sub-module: spi_half_tick, the CLK_DIV divider emitting a one-cycle tick per half-period; enabled only outside IDLE and DONE.
- FSM and shift registers stay in spi_cmd_master.

Test Plan:
- Write, CLK_DIV=4, rw=1 addr=0x00 wdata=0xF0 → bench collects 16'h80F0 on COPI at rising SCLK; 16 SCLK pulses of period 8; ncs low 136 cycles; done at cycle 141; rdata stays 0x00.
- Read, rw=0 addr=0x04, CIPO model drives 0xA5 MSB-first on falling edges during the data phase → COPI carries 16'h0400, rdata=0xA5 at done, busy low the next cycle.
- Busy rejection: second start with addr=0x7F pulsed at cycle 20 of a frame → exactly one frame on the bus (addr 0x00), one done pulse.
- Back-to-back: start held high across two frames (0x8155 then 0x82AA) → both frames correct, nCS high for 6 cycles between them.
- Reset mid-frame: rst_n low at the 5th SCLK rising edge → ncs=1 and sclk=0 in the same cycle, no done; a subsequent write of 0x8301 completes correctly.
- CLK_DIV=1 instance: write 0x80FF → SCLK period 2, done at cycle 36, frame bits correct.
